piton_dcr_core_ctrl: RTL and testbench

Register-mapped front end that turns memory-mapped stores from the OpenPiton chipset side into Vortex DCR write messages and kernel start/status control. It sits directly upstream of the DCR buffer: it drives the buffer's write port (`buffer_wr_valid`/`addr`/`data`) and obeys its `buffer_full` backpressure. It services one MMIO request at a time, with a valid/ready request channel and a valid/ready response channel.

---
 rtl/piton_dcr_core_ctrl_pkg.sv | 24 ++
 rtl/piton_vx_busy_tracker.sv | 47 ++++
 rtl/piton_dcr_core_ctrl.sv | 139 +++++++++++++
 tb/tb_piton_dcr_core_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piton_dcr_core_ctrl_pkg.sv
// Shared definitions for the Piton DCR core controller.
// Holds the register map (as 8-byte word indices), CTRL/STATUS bit positions and FSM states.
package piton_dcr_core_ctrl_pkg;

  localparam logic [8:0] REG_DCR_ADDR = 9'd0;
  localparam logic [8:0] REG_DCR_DATA = 9'd1;
  localparam logic [8:0] REG_STATUS   = 9'd2;
  localparam logic [8:0] REG_CTRL     = 9'd3;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_CLEAR_BIT  = 1;

  localparam int STATUS_FULL_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_DONE_BIT = 2;
  localparam int STATUS_CNT_LSB  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/piton_vx_busy_tracker.sv
// Synchronizes vx_busy and tracks kernel launch state.
// Owns the start pulse, the start-in-flight flag and the sticky done bit.
module piton_vx_busy_tracker (
  input  logic clk,
  input  logic rst,
  input  logic vx_busy,
  input  logic start_req,
  input  logic clear_req,
  output logic start_ok,
  output logic busy_sync,
  output logic done,
  output logic vx_start
);

  logic busy_meta;
  logic busy_prev;
  logic in_flight;

  // A launch is only legal when the core is idle and no earlier launch is still pending.
  assign start_ok = !busy_sync && !in_flight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_meta <= 1'b0;
      busy_sync <= 1'b0;
      busy_prev <= 1'b0;
      in_flight <= 1'b0;
      done      <= 1'b0;
      vx_start  <= 1'b0;
    end else begin
      busy_meta <= vx_busy;
      busy_sync <= busy_meta;
      busy_prev <= busy_sync;
      vx_start  <= start_req && start_ok;
      if (start_req && start_ok)
        in_flight <= 1'b1;
      else if (busy_sync)
        in_flight <= 1'b0;
      // A falling edge on the same cycle as a clear must still leave done set.
      if (busy_prev && !busy_sync)
        done <= 1'b1;
      else if (clear_req)
        done <= 1'b0;
    end
  end

endmodule

// File: rtl/piton_dcr_core_ctrl.sv
// MMIO front end turning chipset stores into Vortex DCR buffer pushes and kernel start/status control.
// Serves one request at a time: IDLE accepts, PUSH waits out buffer backpressure, RESP holds the reply.
module piton_dcr_core_ctrl
  import piton_dcr_core_ctrl_pkg::*;
#(
  parameter int VX_DCR_ADDR_WIDTH = 8,
  parameter int VX_DCR_DATA_WIDTH = 32,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [11:0]                  req_addr,
  input  logic [63:0]                  req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [63:0]                  resp_rdata,
  output logic                         resp_err,
  output logic                         buffer_wr_valid,
  output logic [VX_DCR_ADDR_WIDTH-1:0] buffer_wr_addr,
  output logic [VX_DCR_DATA_WIDTH-1:0] buffer_wr_data,
  input  logic                         buffer_full,
  output logic                         vx_start,
  input  logic                         vx_busy
);

  state_t state, state_next;

  logic [VX_DCR_ADDR_WIDTH-1:0] staged_addr;
  logic [VX_DCR_DATA_WIDTH-1:0] last_data;
  logic [CNT_WIDTH-1:0]         push_cnt;
  logic [8:0]                   req_word;
  logic                         req_fire;
  logic                         start_req;
  logic                         clear_req;
  logic                         start_ok;
  logic                         busy_sync;
  logic                         done;
  logic [63:0]                  status_word;
  logic [63:0]                  rd_data;
  logic                         rd_err;
  logic                         unused_bits;

  assign unused_bits = ^{req_addr[2:0], req_wdata};
  assign req_word    = req_addr[11:3];
  assign req_fire    = req_valid && req_ready;
  assign start_req   = req_fire && req_we && (req_word == REG_CTRL) && req_wdata[CTRL_START_BIT];
  assign clear_req   = req_fire && req_we && (req_word == REG_CTRL) && req_wdata[CTRL_CLEAR_BIT];

  piton_vx_busy_tracker u_busy_tracker (
    .clk       (clk),
    .rst       (rst),
    .vx_busy   (vx_busy),
    .start_req (start_req),
    .clear_req (clear_req),
    .start_ok  (start_ok),
    .busy_sync (busy_sync),
    .done      (done),
    .vx_start  (vx_start)
  );

  always_comb begin
    status_word = '0;
    status_word[STATUS_FULL_BIT] = buffer_full;
    status_word[STATUS_BUSY_BIT] = busy_sync;
    status_word[STATUS_DONE_BIT] = done;
    status_word[STATUS_CNT_LSB +: CNT_WIDTH] = push_cnt;
  end

  // Response fields are computed at accept time and frozen until the reply is consumed.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (req_word)
      REG_DCR_ADDR: if (!req_we) rd_data = 64'(staged_addr);
      REG_DCR_DATA: if (!req_we) rd_data = 64'(last_data);
      REG_STATUS:   if (!req_we) rd_data = status_word;
      REG_CTRL:     rd_err = req_we && req_wdata[CTRL_START_BIT] && !start_ok;
      default:      rd_err = 1'b1;
    endcase
  end

  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    buffer_wr_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = !rst;
        if (req_fire)
          state_next = (req_we && (req_word == REG_DCR_DATA)) ? ST_PUSH : ST_RESP;
      end
      ST_PUSH: begin
        buffer_wr_valid = !buffer_full;
        if (!buffer_full)
          state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      staged_addr    <= '0;
      last_data      <= '0;
      push_cnt       <= '0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      buffer_wr_addr <= '0;
      buffer_wr_data <= '0;
    end else begin
      state <= state_next;
      if (req_fire) begin
        resp_rdata <= rd_data;
        resp_err   <= rd_err;
        if (req_we && (req_word == REG_DCR_ADDR))
          staged_addr <= req_wdata[VX_DCR_ADDR_WIDTH-1:0];
        if (req_we && (req_word == REG_DCR_DATA)) begin
          buffer_wr_addr <= staged_addr;
          buffer_wr_data <= req_wdata[VX_DCR_DATA_WIDTH-1:0];
        end
      end
      if (buffer_wr_valid) begin
        push_cnt  <= push_cnt + CNT_WIDTH'(1);
        last_data <= buffer_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_piton_dcr_core_ctrl.sv
// Directed testbench for piton_dcr_core_ctrl: register access, DCR pushes under backpressure,
// kernel start/done handling, error responses and reset in the middle of a push.
module tb_piton_dcr_core_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [11:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        buffer_wr_valid;
  logic [7:0]  buffer_wr_addr;
  logic [31:0] buffer_wr_data;
  logic        buffer_full;
  logic        vx_start;
  logic        vx_busy;

  int          vec_count;
  int          miscompares;
  int          cycle;
  int          accept_cycle;
  int          push_seen;
  int          start_seen;
  int          start_cycle;
  logic [7:0]  last_push_addr;
  logic [31:0] last_push_data;
  logic [63:0] rsp_data;
  logic        rsp_err;
  int          rsp_lat;

  piton_dcr_core_ctrl #(
    .VX_DCR_ADDR_WIDTH (8),
    .VX_DCR_DATA_WIDTH (32),
    .CNT_WIDTH         (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .buffer_wr_valid (buffer_wr_valid),
    .buffer_wr_addr  (buffer_wr_addr),
    .buffer_wr_data  (buffer_wr_data),
    .buffer_full     (buffer_full),
    .vx_start        (vx_start),
    .vx_busy         (vx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Passive record of every buffer push and start pulse the DUT emits.
  always @(negedge clk) begin
    if (buffer_wr_valid) begin
      push_seen      = push_seen + 1;
      last_push_addr = buffer_wr_addr;
      last_push_data = buffer_wr_data;
    end
    if (vx_start) begin
      start_seen  = start_seen + 1;
      start_cycle = cycle;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vec_count = vec_count + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [11:0] addr, input logic [63:0] wdata);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput("accept_timeout", 64'(req_ready), 64'd1);
    accept_cycle = cycle;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitResponse();
    int n;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) checkOutput("resp_timeout", 64'(resp_valid), 64'd1);
    rsp_lat  = cycle - accept_cycle;
    rsp_data = resp_rdata;
    rsp_err  = resp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_count = 0; miscompares = 0; cycle = 0; accept_cycle = 0;
    push_seen = 0; start_seen = 0; start_cycle = 0;
    last_push_addr = '0; last_push_data = '0;
    rsp_data = '0; rsp_err = 1'b0; rsp_lat = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1; buffer_full = 1'b0; vx_busy = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("rst_wr_valid", 64'(buffer_wr_valid), 64'd0);
    checkOutput("rst_vx_start", 64'(vx_start), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_req_ready", 64'(req_ready), 64'd1);
    idleCycles(1);

    // Stage address 0x05, push 0xDEADBEEF
    applyStimulus(1'b1, 12'h000, 64'h0000_0000_0000_0005); waitResponse();
    checkOutput("wr_addr_lat", 64'(rsp_lat), 64'd1);
    checkOutput("wr_addr_err", 64'(rsp_err), 64'd0);
    applyStimulus(1'b0, 12'h000, 64'h0); waitResponse();
    checkOutput("rd_addr", rsp_data, 64'h5);
    applyStimulus(1'b1, 12'h008, 64'hFFFF_0000_DEAD_BEEF); waitResponse();
    checkOutput("push1_lat", 64'(rsp_lat), 64'd2);
    checkOutput("push1_err", 64'(rsp_err), 64'd0);
    checkOutput("push1_rdata", rsp_data, 64'h0);
    checkOutput("push1_count", 64'(push_seen), 64'd1);
    checkOutput("push1_addr", 64'(last_push_addr), 64'h05);
    checkOutput("push1_data", 64'(last_push_data), 64'hDEAD_BEEF);
    applyStimulus(1'b0, 12'h010, 64'h0); waitResponse();
    checkOutput("status_cnt1", rsp_data, 64'h0000_0000_0001_0000);
    applyStimulus(1'b0, 12'h00F, 64'h0); waitResponse();
    checkOutput("rd_last_data", rsp_data, 64'hDEAD_BEEF);

    // Address truncates to 8 bits; push held off by a full buffer for 5 cycles
    applyStimulus(1'b1, 12'h000, 64'h0000_0000_0000_01A3); waitResponse();
    applyStimulus(1'b0, 12'h000, 64'h0); waitResponse();
    checkOutput("rd_addr_trunc", rsp_data, 64'hA3);
    buffer_full = 1'b1;
    applyStimulus(1'b1, 12'h008, 64'h0000_0000_1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("full_no_push%0d", i), 64'(buffer_wr_valid), 64'd0);
      checkOutput($sformatf("full_no_resp%0d", i), 64'(resp_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    buffer_full = 1'b0;
    @(negedge clk);
    checkOutput("full_push_now", 64'(buffer_wr_valid), 64'd1);
    checkOutput("full_push_addr", 64'(buffer_wr_addr), 64'hA3);
    checkOutput("full_push_data", 64'(buffer_wr_data), 64'h1234_5678);
    waitResponse();
    checkOutput("full_resp_lat", 64'(rsp_lat), 64'd7);
    checkOutput("full_push_total", 64'(push_seen), 64'd2);
    buffer_full = 1'b1;
    applyStimulus(1'b0, 12'h010, 64'h0); waitResponse();
    checkOutput("status_full", rsp_data, 64'h0000_0000_0002_0001);
    buffer_full = 1'b0;

    // Kernel start, in-flight rejection, busy, done, clear
    applyStimulus(1'b1, 12'h018, 64'h1); waitResponse();
    checkOutput("start_err", 64'(rsp_err), 64'd0);
    idleCycles(2);
    checkOutput("start_pulses", 64'(start_seen), 64'd1);
    checkOutput("start_timing", 64'(start_cycle - accept_cycle), 64'd1);
    applyStimulus(1'b1, 12'h018, 64'h1); waitResponse();
    checkOutput("inflight_err", 64'(rsp_err), 64'd1);
    vx_busy = 1'b1;
    idleCycles(10);
    applyStimulus(1'b0, 12'h010, 64'h0); waitResponse();
    checkOutput("status_busy", rsp_data, 64'h0000_0000_0002_0002);
    applyStimulus(1'b1, 12'h018, 64'h1); waitResponse();
    checkOutput("busy_start_err", 64'(rsp_err), 64'd1);
    vx_busy = 1'b0;
    idleCycles(5);
    checkOutput("no_extra_start", 64'(start_seen), 64'd1);
    applyStimulus(1'b0, 12'h010, 64'h0); waitResponse();
    checkOutput("status_done", rsp_data, 64'h0000_0000_0002_0004);
    applyStimulus(1'b1, 12'h018, 64'h2); waitResponse();
    checkOutput("clear_err", 64'(rsp_err), 64'd0);
    applyStimulus(1'b0, 12'h010, 64'h0); waitResponse();
    checkOutput("status_cleared", rsp_data, 64'h0000_0000_0002_0000);
    applyStimulus(1'b1, 12'h018, 64'h3); waitResponse();
    checkOutput("clear_start_err", 64'(rsp_err), 64'd0);
    idleCycles(2);
    checkOutput("clear_start_pulse", 64'(start_seen), 64'd2);

    // STATUS writes are ignored silently; unmapped offsets error out
    applyStimulus(1'b1, 12'h010, 64'hFFFF); waitResponse();
    checkOutput("status_wr_err", 64'(rsp_err), 64'd0);
    resp_ready = 1'b0;
    applyStimulus(1'b0, 12'h020, 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_valid%0d", i), 64'(resp_valid), 64'd1);
      checkOutput($sformatf("hold_err%0d", i), 64'(resp_err), 64'd1);
      checkOutput($sformatf("hold_rdata%0d", i), resp_rdata, 64'h0);
      checkOutput($sformatf("hold_ready%0d", i), 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("hold_release_ready", 64'(req_ready), 64'd1);
    checkOutput("hold_release_valid", 64'(resp_valid), 64'd0);
    idleCycles(1);
    applyStimulus(1'b1, 12'h028, 64'h1234); waitResponse();
    checkOutput("unmapped_wr_err", 64'(rsp_err), 64'd1);

    // Reset while stuck in PUSH drops the transaction
    buffer_full = 1'b1;
    applyStimulus(1'b1, 12'h008, 64'h55);
    @(negedge clk);
    checkOutput("pre_rst_no_push", 64'(buffer_wr_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idleCycles(2);
    buffer_full = 1'b0;
    rst = 1'b0;
    idleCycles(4);
    @(negedge clk);
    checkOutput("rst_push_dropped", 64'(push_seen), 64'd2);
    checkOutput("rst_idle_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_idle_resp", 64'(resp_valid), 64'd0);
    idleCycles(1);
    applyStimulus(1'b0, 12'h010, 64'h0); waitResponse();
    checkOutput("rst_status_zero", rsp_data, 64'h0);
    applyStimulus(1'b0, 12'h000, 64'h0); waitResponse();
    checkOutput("rst_addr_zero", rsp_data, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
